// File: rtl/cv32e40s_rf_ecc_scrubber.sv
// Background ECC scrubber for the register file: steals free read-port cycles,
// re-encodes each word's data field and flags check-bit mismatches. Never writes.
module cv32e40s_rf_ecc_scrubber #(
  parameter  int unsigned REGFILE_NUM_WORDS  = 32,
  parameter  int unsigned SCRUB_INTERVAL     = 64,
  parameter  int unsigned ERR_CNT_WIDTH      = 8,
  localparam int unsigned REGFILE_WORD_WIDTH = 38,
  localparam int unsigned AW                 = $clog2(REGFILE_NUM_WORDS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable_i,
  input  logic                          port_free_i,
  output logic                          rvalid_o,
  output logic [AW-1:0]                 raddr_o,
  input  logic [REGFILE_WORD_WIDTH-1:0] rdata_i,
  input  logic [AW-1:0]                 waddr_i,
  input  logic                          we_i,
  output logic                          ecc_err_o,
  output logic [AW-1:0]                 err_addr_o,
  output logic [ERR_CNT_WIDTH-1:0]      err_cnt_o,
  output logic                          sweep_done_o
);

  localparam int unsigned     CW        = $clog2(SCRUB_INTERVAL + 1);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(REGFILE_NUM_WORDS - 1);
  localparam logic [CW-1:0]   CNT_LOAD  = CW'(SCRUB_INTERVAL - 1);

  // Same check-bit equations as the regfile write-path encoder; word = {chk[5:0], data[31:0]}.
  function automatic logic [5:0] rf_ecc_enc(input logic [31:0] d);
    logic [5:0] c;
    c[0] = ^(d & 32'h56AA_AD5B);
    c[1] = ^(d & 32'h9B33_366D);
    c[2] = ^(d & 32'hE3C3_C78E);
    c[3] = ^(d & 32'h03FC_07F0);
    c[4] = ^(d & 32'h03FF_F800);
    c[5] = ^(d & 32'hFC00_0000);
    return c;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_CHECK} state_e;

  state_e                   state_q, state_d;
  logic [AW-1:0]            addr_q, addr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [31:0]              data_q, data_d;
  logic [5:0]               chk_q, chk_d;
  logic                     stale_q, stale_d;
  logic [AW-1:0]            err_addr_q, err_addr_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     mismatch;

  assign mismatch   = (rf_ecc_enc(data_q) != chk_q);
  assign err_addr_o = err_addr_q;
  assign err_cnt_o  = err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= AW'(1);
      cnt_q      <= '0;
      data_q     <= '0;
      chk_q      <= '0;
      stale_q    <= 1'b0;
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      chk_q      <= chk_d;
      stale_q    <= stale_d;
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    chk_d        = chk_q;
    stale_d      = stale_q;
    err_addr_d   = err_addr_q;
    err_cnt_d    = err_cnt_q;
    rvalid_o     = 1'b0;
    raddr_o      = '0;
    ecc_err_o    = 1'b0;
    sweep_done_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          state_d = S_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (!enable_i)       state_d = S_IDLE;
        else if (cnt_q == '0) state_d = S_READ;
        else                 cnt_d   = cnt_q - CW'(1);
      end
      S_READ: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (port_free_i) begin
          rvalid_o = 1'b1;
          raddr_o  = addr_q;
          data_d   = rdata_i[31:0];
          chk_d    = rdata_i[37:32];
          // A same-cycle WB write makes the sampled word obsolete.
          stale_d  = we_i && (waddr_i == addr_q);
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (mismatch && !stale_q) begin
          ecc_err_o  = 1'b1;
          err_addr_d = addr_q;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        end
        if (addr_q == LAST_ADDR) begin
          addr_d       = AW'(1);
          sweep_done_o = 1'b1;
        end else begin
          addr_d = addr_q + AW'(1);
        end
        if (enable_i) begin
          state_d = S_WAIT;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cv32e40s_rf_ecc_scrubber.sv
// Scoreboard bench for the regfile ECC scrubber: two instances (default-ish and a
// small 2-bit-counter build) sharing clock and reset, each with its own regfile model.
module tb_cv32e40s_rf_ecc_scrubber;
  localparam int N1 = 32, AW1 = 5, N2 = 8, AW2 = 3;
  localparam logic [31:0] MASK [6] = '{32'h56AA_AD5B, 32'h9B33_366D, 32'hE3C3_C78E,
                                       32'h03FC_07F0, 32'h03FF_F800, 32'hFC00_0000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           en1 = 0, pf1 = 0, we1 = 0, rv1, err1, done1;
  logic [AW1-1:0] ra1, wa1 = '0, eaddr1;
  logic [37:0]    rd1;
  logic [7:0]     cnt1;
  logic           en2 = 0, pf2 = 0, we2 = 0, rv2, err2, done2;
  logic [AW2-1:0] ra2, wa2 = '0, eaddr2;
  logic [37:0]    rd2;
  logic [1:0]     cnt2;

  logic [37:0] rf1 [N1];
  logic [37:0] rf2 [N2];
  assign rd1 = rf1[ra1];
  assign rd2 = rf2[ra2];

  cv32e40s_rf_ecc_scrubber #(.REGFILE_NUM_WORDS(N1), .SCRUB_INTERVAL(4), .ERR_CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(en1), .port_free_i(pf1), .rvalid_o(rv1), .raddr_o(ra1),
    .rdata_i(rd1), .waddr_i(wa1), .we_i(we1), .ecc_err_o(err1), .err_addr_o(eaddr1),
    .err_cnt_o(cnt1), .sweep_done_o(done1));

  cv32e40s_rf_ecc_scrubber #(.REGFILE_NUM_WORDS(N2), .SCRUB_INTERVAL(1), .ERR_CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable_i(en2), .port_free_i(pf2), .rvalid_o(rv2), .raddr_o(ra2),
    .rdata_i(rd2), .waddr_i(wa2), .we_i(we2), .ecc_err_o(err2), .err_addr_o(eaddr2),
    .err_cnt_o(cnt2), .sweep_done_o(done2));

  typedef struct {int addr; int cyc;} rd_t;
  rd_t rd_q[$];
  int  err_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, last_rd_addr = -1, last_rd_cyc = -1;
  int s_cyc;
  logic s_rv, s_err, s_done, s2_rv, s2_err;
  logic [AW1-1:0] s_ra, s_eaddr;
  logic [AW2-1:0] s2_ra, s2_eaddr;
  logic [7:0] s_cnt;
  logic [1:0] s2_cnt;

  function automatic logic [5:0] enc(input logic [31:0] d);
    logic [5:0] c = '0;
    for (int b = 0; b < 6; b++)
      for (int i = 0; i < 32; i++)
        if (d[i] && MASK[b][i]) c[b] = ~c[b];
    return c;
  endfunction

  // Sample mid-cycle, retire reads/errors against the queues, then move to the next cycle start.
  task automatic step();
    rd_t e;
    int  x;
    @(negedge clk);
    s_cyc = cyc;
    if (rv1) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++; $display("FAIL sb_read unexpected read: raddr=%0d cyc=%0d", ra1, cyc);
      end else begin
        e = rd_q.pop_front();
        if (int'(ra1) != e.addr || (e.cyc >= 0 && cyc != e.cyc)) begin
          errors++;
          $display("FAIL sb_read: got addr=%0d cyc=%0d, expected addr=%0d cyc=%0d", ra1, cyc, e.addr, e.cyc);
        end
      end
      last_rd_addr = int'(ra1); last_rd_cyc = cyc;
    end
    if (err1) begin
      checks++;
      if (err_q.size() == 0) begin
        errors++; $display("FAIL sb_err unexpected ecc_err: last read=%0d cyc=%0d", last_rd_addr, cyc);
      end else begin
        x = err_q.pop_front();
        if (last_rd_addr != x || last_rd_cyc != cyc - 1) begin
          errors++;
          $display("FAIL sb_err: got read addr=%0d at cyc=%0d (err cyc %0d), expected addr=%0d", last_rd_addr, last_rd_cyc, cyc, x);
        end
      end
    end
    s_rv = rv1; s_ra = ra1; s_err = err1; s_done = done1; s_eaddr = eaddr1; s_cnt = cnt1;
    s2_rv = rv2; s2_ra = ra2; s2_err = err2; s2_eaddr = eaddr2; s2_cnt = cnt2;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    for (int i = 0; i < N1; i++) begin d = $urandom; rf1[i] = {enc(d), d}; end
    for (int i = 0; i < N2; i++) begin d = $urandom; rf2[i] = {enc(d) ^ 6'b000100, d}; end
    rst_n = 0; en1 = 1; pf1 = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rv1 !== 0 || ra1 !== 0 || err1 !== 0 || done1 !== 0) begin
      errors++; $display("FAIL reset_ctl: rv=%b ra=%0d err=%b done=%b, expected all 0", rv1, ra1, err1, done1);
    end
    checks++;
    if (eaddr1 !== 0 || cnt1 !== 0 || cnt2 !== 0 || rv2 !== 0) begin
      errors++; $display("FAIL reset_stat: eaddr=%0d cnt=%0d cnt2=%0d rv2=%b, expected 0", eaddr1, cnt1, cnt2, rv2);
    end
    en1 = 0;
    @(posedge clk); #1;
    rst_n = 1;
    repeat (3) begin
      step();
      checks++;
      if (s_rv !== 0) begin errors++; $display("FAIL idle_no_read: rvalid=%b, expected 0", s_rv); end
    end
  endtask

  task automatic test_clean_sweep();
    int ndone = 0, done_cyc = -1;
    cyc = 0; en1 = 1; pf1 = 1;
    for (int k = 1; k < N1; k++) rd_q.push_back('{k, 5 + (k - 1) * 6});
    repeat (188) begin
      step();
      if (s_done) begin ndone++; done_cyc = s_cyc; end
    end
    checks++;
    if (ndone != 1 || done_cyc != 186) begin
      errors++; $display("FAIL sweep_done: pulses=%0d at cyc=%0d, expected 1 at 186", ndone, done_cyc);
    end
    checks++;
    if (rd_q.size() != 0) begin errors++; $display("FAIL clean_reads: %0d reads missing, expected 0", rd_q.size()); end
    checks++;
    if (s_cnt !== 0) begin errors++; $display("FAIL clean_cnt: err_cnt=%0d, expected 0", s_cnt); end
  endtask

  task automatic test_ecc_error();
    rf1[7][32] = ~rf1[7][32];
    for (int sw = 1; sw <= 2; sw++) begin
      int nerr = 0;
      logic pend = 0, seen = 0;
      for (int k = 1; k < N1; k++) rd_q.push_back('{k, -1});
      err_q.push_back(7);
      for (int i = 0; i < 250 && !seen; i++) begin
        step();
        if (pend) begin
          checks++;
          if (s_eaddr !== 7 || int'(s_cnt) != sw) begin
            errors++; $display("FAIL err_report: err_addr=%0d err_cnt=%0d, expected 7 and %0d", s_eaddr, s_cnt, sw);
          end
          pend = 0;
        end
        if (s_err) begin nerr++; pend = 1; end
        seen = s_done;
      end
      checks++;
      if (!seen || nerr != 1 || rd_q.size() != 0) begin
        errors++; $display("FAIL err_sweep%0d: done=%b pulses=%0d missing=%0d, expected 1/1/0", sw, seen, nerr, rd_q.size());
      end
    end
    checks++;
    if (s_cnt !== 8'd2) begin errors++; $display("FAIL err_cnt_2: err_cnt=%0d, expected 2", s_cnt); end
    rf1[7][32] = ~rf1[7][32];
  endtask

  task automatic test_port_busy();
    int c1;
    logic seen = 0;
    pf1 = 0;
    rd_q.push_back('{1, -1});
    repeat (14) begin
      step();
      checks++;
      if (s_rv !== 0) begin errors++; $display("FAIL busy_no_read: rvalid=%b cyc=%0d, expected 0", s_rv, s_cyc); end
    end
    pf1 = 1;
    step();
    c1 = s_cyc;
    checks++;
    if (s_rv !== 1 || s_ra !== 1) begin
      errors++; $display("FAIL busy_release: rvalid=%b raddr=%0d, expected 1 and 1", s_rv, s_ra);
    end
    rd_q.push_back('{2, -1});
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = s_rv;
    end
    checks++;
    if (!seen || s_ra !== 2 || s_cyc != c1 + 6) begin
      errors++; $display("FAIL busy_next: seen=%b raddr=%0d cyc=%0d, expected x2 at %0d", seen, s_ra, s_cyc, c1 + 6);
    end
  endtask

  task automatic test_collision();
    logic hit = 0, seen4 = 0, any_err = 0;
    rf1[3][33] = ~rf1[3][33];
    rd_q.push_back('{3, -1});
    rd_q.push_back('{4, -1});
    for (int i = 0; i < 20 && !seen4; i++) begin
      if (rv1 && ra1 == 3) begin we1 = 1; wa1 = 3; end
      else begin we1 = 0; wa1 = 0; end
      step();
      if (s_rv && s_ra == 3 && we1) hit = 1;
      if (s_err) any_err = 1;
      seen4 = s_rv && (s_ra == 4);
    end
    we1 = 0;
    checks++;
    if (!hit || !seen4) begin errors++; $display("FAIL collide_seq: x3 hit=%b x4 read=%b, expected 1/1", hit, seen4); end
    checks++;
    if (any_err || s_cnt !== 8'd2) begin
      errors++; $display("FAIL collide_stale: ecc_err seen=%b err_cnt=%0d, expected 0 and 2", any_err, s_cnt);
    end
    rf1[3][33] = ~rf1[3][33];
  endtask

  task automatic test_disable();
    int r0;
    logic seen = 0;
    for (int k = 5; k <= 9; k++) rd_q.push_back('{k, -1});
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      seen = s_rv && (s_ra == 9);
    end
    step();
    en1 = 0;
    repeat (12) begin
      step();
      checks++;
      if (s_rv !== 0) begin errors++; $display("FAIL dis_idle: rvalid=%b cyc=%0d, expected 0", s_rv, s_cyc); end
    end
    en1 = 1;
    r0 = cyc;
    rd_q.push_back('{10, r0 + 5});
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      step();
      seen = s_rv;
    end
    checks++;
    if (!seen || s_ra !== 10 || s_cyc != r0 + 5) begin
      errors++; $display("FAIL dis_resume: seen=%b raddr=%0d cyc=%0d, expected x10 at %0d", seen, s_ra, s_cyc, r0 + 5);
    end
    en1 = 0;
    repeat (3) step();
    checks++;
    if (s_eaddr !== 7 || rd_q.size() != 0) begin
      errors++; $display("FAIL dis_hold: err_addr=%0d missing=%0d, expected 7 and 0", s_eaddr, rd_q.size());
    end
  endtask

  task automatic test_err_saturation();
    int exp_cnt [5];
    int n = 0;
    logic pend = 0;
    exp_cnt = '{1, 2, 3, 3, 3};
    en2 = 1; pf2 = 1;
    for (int i = 0; i < 40 && (n < 5 || pend); i++) begin
      step();
      if (pend) begin
        checks++;
        if (int'(s2_cnt) != exp_cnt[n - 1] || int'(s2_eaddr) != n) begin
          errors++; $display("FAIL sat_cnt%0d: err_cnt=%0d err_addr=%0d, expected %0d and %0d", n, s2_cnt, s2_eaddr, exp_cnt[n - 1], n);
        end
        pend = 0;
      end
      if (s2_err) begin n++; pend = 1; end
    end
    checks++;
    if (n != 5) begin errors++; $display("FAIL sat_pulses: ecc_err pulses=%0d, expected 5", n); end
  endtask

  task automatic test_reset_mid();
    logic seen = 0;
    rst_n = 0;
    @(negedge clk);
    checks++;
    if (cnt2 !== 0 || eaddr2 !== 0 || rv2 !== 0 || err2 !== 0 || done2 !== 0) begin
      errors++; $display("FAIL mid_reset: cnt=%0d eaddr=%0d rv=%b err=%b done=%b, expected 0", cnt2, eaddr2, rv2, err2, done2);
    end
    @(posedge clk); #1;
    rst_n = 1; en2 = 1;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = s2_rv;
    end
    checks++;
    if (!seen || s2_ra !== 1 || s2_cnt !== 0) begin
      errors++; $display("FAIL mid_restart: seen=%b raddr=%0d cnt=%0d, expected x1 and cnt 0", seen, s2_ra, s2_cnt);
    end
    en2 = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_ecc_error();
    test_port_busy();
    test_collision();
    test_disable();
    test_err_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
